// File: rtl/rec_pkg.sv
// Shared types and the round-robin helper for the recognizer scheduler family.
package rec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } rec_sched_state_t;

    localparam int REC_MAX_REQ = 8;

    // First requesting index cyclically after ptr; unused upper request bits must be zero,
    // which makes the 8-way scan equivalent to a wrap at the real requester count.
    function automatic logic [2:0] rr_next(input logic [7:0] req, input logic [2:0] ptr);
        logic [2:0] idx;
        logic [2:0] cand;
        logic       found;
        idx   = ptr;
        found = 1'b0;
        for (int k = 1; k <= REC_MAX_REQ; k++) begin
            cand = ptr + k[2:0];
            if (req[cand] && !found) begin
                idx   = cand;
                found = 1'b1;
            end else begin
                idx   = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rec_rr_arb.sv
// Combinational round-robin picker: returns the first requester after ptr.
module rec_rr_arb
    import rec_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [7:0] req_pad_s;
    logic [2:0] ptr_pad_s;

    // Widen request and pointer to the helper's fixed 8-way form.
    always_comb begin
        req_pad_s              = 8'd0;
        req_pad_s[N_REQ-1:0]   = req;
        ptr_pad_s              = 3'd0;
        ptr_pad_s[IDX_W-1:0]   = ptr;
    end

    assign valid = |req;
    assign idx   = IDX_W'(rr_next(req_pad_s, ptr_pad_s));

endmodule

// File: rtl/rec_scheduler.sv
// Round-robin scheduler sharing one bit-serial recognizer among N_REQ requesters.
// Optional REC_SCHED_STATS_EN adds a saturating match_frames counter.
module rec_scheduler
    import rec_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int Z_LAT = 1,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic                      CK,
    input  logic                      RESET,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*W-1:0]        data,
    output logic [N_REQ-1:0]          ack,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          hit_cnt,
`ifdef REC_SCHED_STATS_EN
    output logic [15:0]               match_frames,
`endif
    output logic                      rec_x,
    input  logic                      rec_z
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CYC_W = $clog2(W + Z_LAT + 1);
    localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(N_REQ - 1);
    localparam logic [CYC_W-1:0] SHIFT_END = CYC_W'(W - 1);
    localparam logic [CYC_W-1:0] LAST_CYC  = CYC_W'(W + Z_LAT - 1);
    localparam logic [CYC_W-1:0] WIN_START = CYC_W'(Z_LAT);
    localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
    localparam logic [N_REQ-1:0] ACK_ONE   = N_REQ'(1);

    rec_sched_state_t  state_q, state_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [W-2:0]      sh_q, sh_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              rec_x_q, rec_x_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              arb_valid_s;
    logic [IDX_W-1:0]  arb_idx_s;
    logic [W-1:0]      sel_word_s;
    logic              in_win_s;

    rec_rr_arb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .valid (arb_valid_s),
        .idx   (arb_idx_s)
    );

    // Mux out the word of the requester the arbiter is picking.
    always_comb begin
        sel_word_s = {W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx_s == IDX_W'(i)) begin
                sel_word_s = data[i*W +: W];
            end else begin
                sel_word_s = sel_word_s;
            end
        end
    end

    // Next-state, serializer and hit-window logic.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        sh_d       = sh_q;
        cyc_d      = cyc_q;
        acc_d      = acc_q;
        hit_cnt_d  = hit_cnt_q;
        busy_d     = busy_q;
        rec_x_d    = 1'b0;
        done_d     = 1'b0;
        ack_d      = {N_REQ{1'b0}};

        // rec_z only counts inside the aligned W-sample window.
        in_win_s = ((state_q == SHIFT) || (state_q == DRAIN)) && (cyc_q >= WIN_START);
        if (in_win_s && rec_z) begin
            acc_d = acc_q + CNT_W'(1);
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            IDLE: begin
                if (arb_valid_s) begin
                    state_d    = SHIFT;
                    grant_id_d = arb_idx_s;
                    sh_d       = sel_word_s[W-2:0];
                    rec_x_d    = sel_word_s[W-1];
                    cyc_d      = {CYC_W{1'b0}};
                    acc_d      = {CNT_W{1'b0}};
                    busy_d     = 1'b1;
                end else begin
                    state_d    = IDLE;
                end
            end
            SHIFT: begin
                cyc_d = cyc_q + CYC_ONE;
                sh_d  = sh_q << 1'b1;
                if (cyc_q == SHIFT_END) begin
                    rec_x_d = 1'b0;
                    state_d = (Z_LAT == 0) ? REPORT : DRAIN;
                end else begin
                    rec_x_d = sh_q[W-2];
                end
            end
            DRAIN: begin
                cyc_d = cyc_q + CYC_ONE;
                if (cyc_q == LAST_CYC) begin
                    state_d = REPORT;
                end else begin
                    state_d = DRAIN;
                end
            end
            REPORT: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ptr_d   = grant_id_q;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Last window sample: publish the count so it lands with done/ack in REPORT.
        if (in_win_s && (cyc_q == LAST_CYC)) begin
            hit_cnt_d = acc_d;
            done_d    = 1'b1;
            ack_d     = ACK_ONE << grant_id_q;
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
    end

`ifdef REC_SCHED_STATS_EN
    logic [15:0] match_q, match_d;

    // Saturating count of frames that saw at least one hit.
    always_comb begin
        if (done_d && (hit_cnt_d != {CNT_W{1'b0}}) && (match_q != 16'hFFFF)) begin
            match_d = match_q + 16'd1;
        end else begin
            match_d = match_q;
        end
    end

    // Statistics register.
    always_ff @(posedge CK or negedge RESET) begin
        if (!RESET) begin
            match_q <= 16'd0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match_frames = match_q;
`endif

    // FSM state and all registered outputs.
    always_ff @(posedge CK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            grant_id_q <= {IDX_W{1'b0}};
            ptr_q      <= PTR_RST;
            sh_q       <= {(W-1){1'b0}};
            cyc_q      <= {CYC_W{1'b0}};
            acc_q      <= {CNT_W{1'b0}};
            hit_cnt_q  <= {CNT_W{1'b0}};
            ack_q      <= {N_REQ{1'b0}};
            rec_x_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            sh_q       <= sh_d;
            cyc_q      <= cyc_d;
            acc_q      <= acc_d;
            hit_cnt_q  <= hit_cnt_d;
            ack_q      <= ack_d;
            rec_x_q    <= rec_x_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ack      = ack_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign hit_cnt  = hit_cnt_q;
    assign rec_x    = rec_x_q;

endmodule

// File: doc/rec_scheduler.md
Name: rec_scheduler

Overview:
- Round-robin scheduler that shares one external bit-serial sequence recognizer among N_REQ requesters.
- A granted requester's W-bit word is latched and shifted MSB-first onto the recognizer input (rec_x).
- The recognizer output (rec_z) is counted over an aligned window, and a per-frame hit count is returned with done/ack.
- The block sits between the parallel requesters and the recognizer, and owns the recognizer's input stream exclusively.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 8, frame length in bits
Z_LAT, 1, cycles from a rec_x bit to the rec_z it causes (0..3)
CNT_W, $clog2(W+1), width of hit_cnt

Ports:
CK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester request, level
data  in  N_REQ*W  request words, requester i at bits [i*W +: W]
ack  out  N_REQ  one-hot, one-cycle pulse to the served requester
grant_id  out  $clog2(N_REQ)  index of requester being served (valid when busy=1)
busy  out  1  high from SHIFT through REPORT
done  out  1  one-cycle pulse, coincident with ack
hit_cnt  out  CNT_W  hits in the finished frame, valid when done=1, held until next done
rec_x  out  1  serial bit to recognizer
rec_z  in  1  recognizer detect output

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE; rec_x=0, ack=0, done=0, busy=0, hit_cnt=0, grant_id=0; RR pointer=N_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- FSM states are IDLE, SHIFT, DRAIN and REPORT.
- IDLE:
  - rec_x=0.
  - If any req is high, pick the first requesting index cyclically after the RR pointer.
  - Register grant_id, load the shift register with that requester's data word and clear the hit counter.
  - Go to SHIFT. Otherwise stay in IDLE.
- SHIFT (W cycles):
  - Cycle k (0..W-1) drives rec_x = data bit W-1-k.
  - A bit counter runs 0..W-1; go to DRAIN, or to REPORT if Z_LAT=0.
- DRAIN (Z_LAT cycles): rec_x=0.
- Count window:
  - rec_z is sampled on the cycles from SHIFT cycle Z_LAT through the last DRAIN cycle, exactly W samples.
  - Each high sample increments the hit counter.
  - The counter cannot overflow, since at most W hits fit in CNT_W bits.
  - rec_z outside the window is ignored. This covers patterns completed by drain/idle zeros and residue from the previous frame.
- REPORT (1 cycle):
  - rec_x=0; done=1; ack[grant_id]=1; hit_cnt updated.
  - RR pointer := grant_id.
  - Go to IDLE.
- Frame period is W+Z_LAT+2 cycles back-to-back. At least 2 zero bits separate frames on rec_x.
- Handshake:
  - data[i] needs to be valid only in the IDLE cycle that grants i; it is latched.
  - The requester drops req the cycle after ack. A req still high then is treated as a new request at the lowest RR priority.
- Req changes mid-frame: ignored. The frame completes with the latched word; req deassertion does not abort the frame.
- Simultaneous requests are resolved by RR only. No requester is starved: maximum wait is (N_REQ-1) frames.
- Reset mid-frame: immediate return to reset values, with no done/ack for the aborted frame. The recognizer is expected to be reset by the same RESET.

Optional Feature:
- Macro: REC_SCHED_STATS_EN.
- Defined:
  - Adds output match_frames [15:0], a saturating count of frames whose hit_cnt>0.
  - Increments in the REPORT cycle, holds at 16'hFFFF, and resets to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package rec_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, REPORT} rec_sched_state_t.
  - Function rr_next(req, ptr) returning the next index.
- Sub-module rec_rr_arb: the combinational round-robin picker (req, ptr -> valid, idx), reused by other shared-resource controllers.
- The shift/count datapath stays in rec_scheduler.

Test Plan:
- Bench recognizer model flags overlapping "110" with Z_LAT=1.
- After reset, req=4'b0001 with data0=8'b1101_1000 -> grant_id=0; rec_x serial 1,1,0,1,1,0,0,0; done at cycle 11 after req; hit_cnt=2; ack=4'b0001.
- data0=8'b0000_0011 -> the pattern completes only on the drain zero, so hit_cnt=0. A following frame 8'b0110_0000 gives hit_cnt=1, with no carry-over from the previous frame.
- req=4'b1111 held continuously from reset -> grant order 0,1,2,3,0; one done every 11 cycles.
- req=4'b1010 held -> grants alternate 1,3,1,3. ack never goes to 0 or 2.
- RESET pulled low during SHIFT bit 4 -> rec_x, busy, ack and done are 0 immediately. After release, the next frame starts with grant_id per reset priority (requester 0 first).
- With REC_SCHED_STATS_EN defined, run 3 frames with hits and 1 without -> match_frames=3. Force the counter to 16'hFFFE, then run 2 hit frames -> holds at 16'hFFFF.
